// File: rtl/pmem_arbiter_pkg.sv
// Shared types and constants for the I/D physical-memory arbiter.
// A cache line is moved as BURST_LEN beats of BURST_W bits.
package pmem_arb_types;

  localparam int LINE_W     = 256;
  localparam int BURST_W    = 64;
  localparam int BURST_LEN  = LINE_W / BURST_W;
  localparam int ADDR_W     = 32;
  localparam int OFFSET_W   = 5;
  localparam int BEAT_IDX_W = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } arb_state_t;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;

  function automatic logic [ADDR_W-1:0] line_base(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/pmem_arbiter_burst_buffer.sv
// Line register shared by all bursts: parallel load for writebacks,
// beat-indexed fill for reads, beat-indexed read mux for write beats.
module burst_buffer
  import pmem_arb_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  line_t                 load_line,
  input  logic                  beat_we,
  input  logic [BEAT_IDX_W-1:0] beat_idx,
  input  beat_t                 beat_wdata,
  output line_t                 line,
  output beat_t                 beat_rdata
);

  line_t line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load) begin
      line_d = load_line;
    end else if (beat_we) begin
      line_d[BURST_W*beat_idx +: BURST_W] = beat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line       = line_q;
  assign beat_rdata = line_q[BURST_W*beat_idx +: BURST_W];

endmodule

// File: rtl/pmem_arbiter.sv
// Grants the pmem burst port to the I- or D-cache one line at a time,
// with a bounded D streak so a waiting I fetch cannot starve.
module pmem_arbiter
  import pmem_arb_types::*;
#(
  parameter int MAX_CONSEC_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output line_t             i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  line_t             d_wdata,
  output line_t             d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output beat_t             pmem_wdata,
  input  beat_t             pmem_rdata,
  input  logic              pmem_resp
);

  localparam int STREAK_W = $clog2(MAX_CONSEC_D + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX =
    STREAK_W'(MAX_CONSEC_D);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT =
    BEAT_IDX_W'(BURST_LEN - 1);

  arb_state_t            state_q, state_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  is_d_q, is_d_d;
  line_t                 i_hold_q, i_hold_d;
  line_t                 d_hold_q, d_hold_d;

  logic  buf_load, buf_we;
  line_t buf_line;
  beat_t buf_beat;
  logic  d_req, d_wins, done_i, done_d;

  assign d_req  = d_read | d_write;
  assign d_wins = d_req & (~i_read | (streak_q != STREAK_MAX));

  burst_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_line  (d_wdata),
    .beat_we    (buf_we),
    .beat_idx   (beat_q),
    .beat_wdata (pmem_rdata),
    .line       (buf_line),
    .beat_rdata (buf_beat)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    is_d_d     = is_d_q;
    buf_load   = 1'b0;
    buf_we     = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          is_d_d   = 1'b1;
          addr_d   = line_base(d_addr);
          beat_d   = '0;
          buf_load = d_write;
          state_d  = d_write ? D_WR : D_RD;
          if (!i_read) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (i_read) begin
          is_d_d   = 1'b0;
          addr_d   = line_base(i_addr);
          beat_d   = '0;
          streak_d = '0;
          state_d  = I_RD;
        end
      end
      I_RD, D_RD: begin
        pmem_read = 1'b1;
        pmem_addr = addr_q;
        if (pmem_resp) begin
          buf_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      D_WR: begin
        pmem_write = 1'b1;
        pmem_addr  = addr_q;
        if (pmem_resp) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each client keeps its last line once the shared buffer moves on
  assign done_i     = (state_q == DONE) & ~is_d_q;
  assign done_d     = (state_q == DONE) & is_d_q;
  assign i_resp     = done_i;
  assign d_resp     = done_d;
  assign i_rdata    = done_i ? buf_line : i_hold_q;
  assign d_rdata    = done_d ? buf_line : d_hold_q;
  assign i_hold_d   = i_rdata;
  assign d_hold_d   = d_rdata;
  assign pmem_wdata = (state_q == D_WR) ? buf_beat : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      streak_q <= '0;
      addr_q   <= '0;
      is_d_q   <= 1'b0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      is_d_q   <= is_d_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: line-level memory model, arbitration
// reference model and scenario tasks.
module tb_pmem_arbiter;
  import pmem_arb_types::*;

  localparam int MAX_D = 4;

  logic              clk, rst;
  logic              i_read, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr, pmem_addr;
  line_t             i_rdata, d_rdata, d_wdata;
  logic              i_resp, d_resp;
  logic              pmem_read, pmem_write, pmem_resp;
  beat_t             pmem_wdata, pmem_rdata;

  int checks = 0;
  int failures = 0;
  int gap_mode = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;

  line_t mem [logic [ADDR_W-1:0]];
  beat_t wlog [$];

  pmem_arbiter #(.MAX_CONSEC_D(MAX_D)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < LINE_W / 32; k++) l[32*k +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [31:0] lbase(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  task automatic touch(input logic [31:0] a);
    if (!mem.exists(lbase(a))) mem[lbase(a)] = rand_line();
  endtask

  // Memory: serves beats of the addressed line in order, gaps per gap_mode
  initial begin : responder
    int mcnt, gcnt;
    bit fire;
    line_t l;
    pmem_resp = 0;
    pmem_rdata = '0;
    mcnt = 0;
    gcnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !(pmem_read || pmem_write)) begin
        mcnt = 0;
        gcnt = 0;
        pmem_resp = 0;
      end else begin
        gcnt++;
        if (gap_mode == 0) fire = 1;
        else if (gap_mode > 0) fire = (gcnt % gap_mode) == 0;
        else fire = $urandom_range(0, 1) == 1;
        if (fire && mcnt < BURST_LEN) begin
          if (!mem.exists(pmem_addr)) mem[pmem_addr] = rand_line();
          l = mem[pmem_addr];
          if (pmem_read) begin
            pmem_rdata = l[BURST_W*mcnt +: BURST_W];
          end else begin
            l[BURST_W*mcnt +: BURST_W] = pmem_wdata;
            mem[pmem_addr] = l;
            wlog.push_back(pmem_wdata);
          end
          mcnt++;
        end else begin
          fire = 0;
        end
        pmem_resp = fire;
      end
    end
  end

  always @(negedge clk) begin
    if (i_resp) i_resp_cnt++;
    if (d_resp) d_resp_cnt++;
  end

  always @(posedge clk) begin
    if (!rst) assert (!(d_read && d_write))
      else $error("d_read and d_write high together");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1;
    i_read = 0;
    d_read = 0;
    d_write = 0;
    gap_mode = 0;
    tick();
    tick();
    rst = 0;
    wlog.delete();
  endtask

  task automatic wait_resp(output bit gi, output bit gd,
                           output int cyc, output int cmd_low);
    cyc = 0;
    cmd_low = 0;
    do begin
      tick();
      cyc++;
      if (!(i_resp || d_resp) && !(pmem_read || pmem_write)) cmd_low++;
    end while (!(i_resp || d_resp) && cyc < 200);
    gi = i_resp;
    gd = d_resp;
    checks++;
    if (!(gi || gd)) begin
      failures++;
      $display("FAIL resp_timeout got=none exp=resp within 200");
    end
  endtask

  task automatic test_reset();
    rst = 1;
    i_read = 0;
    d_read = 0;
    d_write = 0;
    i_addr = $urandom();
    d_addr = $urandom();
    d_wdata = rand_line();
    tick();
    tick();
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0000",
               {pmem_read, pmem_write, i_resp, d_resp});
    end
    checks++;
    if ({pmem_addr, pmem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_bus got=%h/%h exp=0", pmem_addr, pmem_wdata);
    end
    checks++;
    if ({i_rdata, d_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata});
    end
    rst = 0;
    tick();
    tick();
    checks++;
    if ({pmem_read, pmem_write, pmem_addr} !== '0) begin
      failures++;
      $display("FAIL idle_no_req got=%b%b/%h exp=0",
               pmem_read, pmem_write, pmem_addr);
    end
  endtask

  task automatic test_i_read();
    line_t exp;
    apply_reset();
    exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    mem[32'h60] = exp;
    i_addr = 32'h60;
    i_read = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if ({pmem_read, i_resp, pmem_addr} !== {1'b1, 1'b0, 32'h60}) begin
        failures++;
        $display("FAIL i_burst_%0d got=%b%b/%h exp=10/60",
                 k, pmem_read, i_resp, pmem_addr);
      end
    end
    tick();
    checks++;
    if ({i_resp, d_resp, pmem_read} !== 3'b100) begin
      failures++;
      $display("FAIL i_done got=%b exp=100", {i_resp, d_resp, pmem_read});
    end
    checks++;
    if (i_rdata !== exp) begin
      failures++;
      $display("FAIL i_rdata got=%h exp=%h", i_rdata, exp);
    end
    i_read = 0;
    tick();
    checks++;
    if ({i_resp, i_rdata} !== {1'b0, exp}) begin
      failures++;
      $display("FAIL i_hold got=%b/%h exp=0/%h", i_resp, i_rdata, exp);
    end
  endtask

  task automatic test_d_write();
    line_t wd;
    bit gi, gd;
    int cyc, cl;
    apply_reset();
    wd = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
          64'h0f1e_2d3c_4b5a_6978, 64'h8796_a5b4_c3d2_e1f0};
    d_addr = 32'h1F4;
    d_wdata = wd;
    d_write = 1;
    tick();
    checks++;
    if ({pmem_write, pmem_read, pmem_addr, pmem_wdata} !==
        {1'b1, 1'b0, 32'h1E0, wd[63:0]}) begin
      failures++;
      $display("FAIL dw_first got=%b%b/%h/%h exp=10/1e0/%h",
               pmem_write, pmem_read, pmem_addr, pmem_wdata, wd[63:0]);
    end
    wait_resp(gi, gd, cyc, cl);
    d_write = 0;
    checks++;
    if ({gd, gi, cyc} !== {1'b1, 1'b0, 32'd4}) begin
      failures++;
      $display("FAIL dw_resp got=d%b i%b c%0d exp=d1 i0 c4", gd, gi, cyc);
    end
    checks++;
    if (wlog.size() != 4) begin
      failures++;
      $display("FAIL dw_beats got=%0d exp=4", wlog.size());
    end
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      checks++;
      if (wlog[k] !== wd[64*k +: 64]) begin
        failures++;
        $display("FAIL dw_beat%0d got=%h exp=%h", k, wlog[k], wd[64*k +: 64]);
      end
    end
    checks++;
    if (mem[32'h1E0] !== wd) begin
      failures++;
      $display("FAIL dw_mem got=%h exp=%h", mem[32'h1E0], wd);
    end
  endtask

  task automatic test_contention();
    logic [31:0] ia, da;
    bit gi, gd;
    int c1, c2, cl;
    apply_reset();
    ia = $urandom();
    da = $urandom();
    touch(ia);
    touch(da);
    i_addr = ia;
    d_addr = da;
    i_read = 1;
    d_read = 1;
    wait_resp(gi, gd, c1, cl);
    checks++;
    if ({gi, gd} !== 2'b01) begin
      failures++;
      $display("FAIL cont_first got=i%b d%b exp=i0 d1", gi, gd);
    end
    checks++;
    if (d_rdata !== mem[lbase(da)]) begin
      failures++;
      $display("FAIL cont_d_rdata got=%h exp=%h", d_rdata, mem[lbase(da)]);
    end
    d_read = 0;
    wait_resp(gi, gd, c2, cl);
    i_read = 0;
    checks++;
    if ({gi, gd, c2} !== {1'b1, 1'b0, 32'd6}) begin
      failures++;
      $display("FAIL cont_second got=i%b d%b c%0d exp=i1 d0 c6", gi, gd, c2);
    end
    checks++;
    if ({i_rdata, d_rdata} !== {mem[lbase(ia)], mem[lbase(da)]}) begin
      failures++;
      $display("FAIL cont_rdata got=%h exp=%h", {i_rdata, d_rdata},
               {mem[lbase(ia)], mem[lbase(da)]});
    end
  endtask

  task automatic test_starvation();
    logic [31:0] ia, da;
    bit gi, gd, exp_i;
    int cyc, cl, streak;
    apply_reset();
    ia = $urandom();
    da = $urandom();
    touch(ia);
    touch(da);
    i_addr = ia;
    d_addr = da;
    i_read = 1;
    d_read = 1;
    streak = 0;
    for (int n = 0; n < 12; n++) begin
      wait_resp(gi, gd, cyc, cl);
      exp_i = (streak == MAX_D);
      checks++;
      if ({gi, gd} !== {exp_i, !exp_i}) begin
        failures++;
        $display("FAIL starve_grant%0d got=i%b d%b exp=i%b", n, gi, gd, exp_i);
      end
      if (exp_i) begin
        checks++;
        if (i_rdata !== mem[lbase(ia)]) begin
          failures++;
          $display("FAIL starve_i%0d got=%h exp=%h", n, i_rdata, mem[lbase(ia)]);
        end
        streak = 0;
        ia = $urandom();
        touch(ia);
        i_addr = ia;
      end else begin
        checks++;
        if (d_rdata !== mem[lbase(da)]) begin
          failures++;
          $display("FAIL starve_d%0d got=%h exp=%h", n, d_rdata, mem[lbase(da)]);
        end
        streak++;
        da = $urandom();
        touch(da);
        d_addr = da;
      end
    end
    i_read = 0;
    d_read = 0;
    tick();
  endtask

  task automatic test_beat_gaps();
    logic [31:0] da, wa;
    line_t wd;
    bit gi, gd;
    int cyc, cl, snap_d, snap_i;
    apply_reset();
    gap_mode = 3;
    da = $urandom();
    touch(da);
    d_addr = da;
    d_read = 1;
    snap_d = d_resp_cnt;
    snap_i = i_resp_cnt;
    wait_resp(gi, gd, cyc, cl);
    d_read = 0;
    checks++;
    if ({gd, cyc, cl} !== {1'b1, 32'd13, 32'd0}) begin
      failures++;
      $display("FAIL gap_rd got=d%b c%0d low%0d exp=d1 c13 low0", gd, cyc, cl);
    end
    checks++;
    if (d_rdata !== mem[lbase(da)]) begin
      failures++;
      $display("FAIL gap_rdata got=%h exp=%h", d_rdata, mem[lbase(da)]);
    end
    tick();
    tick();
    checks++;
    if ((d_resp_cnt - snap_d) != 1 || i_resp_cnt != snap_i) begin
      failures++;
      $display("FAIL gap_resp_count got=%0d/%0d exp=1/0",
               d_resp_cnt - snap_d, i_resp_cnt - snap_i);
    end
    wd = rand_line();
    wa = $urandom();
    wlog.delete();
    d_addr = wa;
    d_wdata = wd;
    d_write = 1;
    wait_resp(gi, gd, cyc, cl);
    d_write = 0;
    checks++;
    if ({gd, cl} !== {1'b1, 32'd0}) begin
      failures++;
      $display("FAIL gap_wr got=d%b low%0d exp=d1 low0", gd, cl);
    end
    checks++;
    if (mem[lbase(wa)] !== wd) begin
      failures++;
      $display("FAIL gap_wr_mem got=%h exp=%h", mem[lbase(wa)], wd);
    end
    gap_mode = 0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] ia, da;
    bit gi, gd;
    int cyc, cl, snap_d;
    apply_reset();
    da = $urandom();
    ia = $urandom();
    touch(da);
    touch(ia);
    d_addr = da;
    d_read = 1;
    tick();
    tick();
    checks++;
    if (pmem_read !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy got=%b exp=1", pmem_read);
    end
    snap_d = d_resp_cnt;
    rst = 1;
    d_read = 0;
    tick();
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp, pmem_addr, pmem_wdata} !== '0) begin
      failures++;
      $display("FAIL mid_outputs got=%b%b%b%b/%h/%h exp=0",
               pmem_read, pmem_write, i_resp, d_resp, pmem_addr, pmem_wdata);
    end
    checks++;
    if ({i_rdata, d_rdata} !== '0) begin
      failures++;
      $display("FAIL mid_rdata got=%h exp=0", {i_rdata, d_rdata});
    end
    rst = 0;
    i_addr = ia;
    i_read = 1;
    wait_resp(gi, gd, cyc, cl);
    i_read = 0;
    checks++;
    if ({gi, gd, cyc} !== {1'b1, 1'b0, 32'd5}) begin
      failures++;
      $display("FAIL mid_after got=i%b d%b c%0d exp=i1 d0 c5", gi, gd, cyc);
    end
    checks++;
    if (i_rdata !== mem[lbase(ia)]) begin
      failures++;
      $display("FAIL mid_i_rdata got=%h exp=%h", i_rdata, mem[lbase(ia)]);
    end
    tick();
    checks++;
    if (d_resp_cnt != snap_d || d_rdata !== '0) begin
      failures++;
      $display("FAIL mid_no_dresp got=%0d/%h exp=0/0", d_resp_cnt - snap_d, d_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] ia, da;
    line_t wd, last_i;
    bit gi, gd, exp_d, have_i;
    int cyc, cl, streak, pi, pd;
    apply_reset();
    gap_mode = -1;
    streak = 0;
    have_i = 0;
    last_i = '0;
    ia = 0;
    da = 0;
    wd = '0;
    for (int r = 0; r < 30; r++) begin
      pi = $urandom_range(0, 1);
      pd = $urandom_range(0, 2);
      if (pi == 0 && pd == 0) pi = 1;
      if (pi != 0) begin
        ia = ($urandom_range(0, 63) << 5) | $urandom_range(0, 31);
        touch(ia);
        i_addr = ia;
        i_read = 1;
      end
      if (pd != 0) begin
        da = 32'h1000_0000 | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
        touch(da);
        d_addr = da;
        if (pd == 2) begin
          wd = rand_line();
          d_wdata = wd;
          wlog.delete();
          d_write = 1;
        end else begin
          d_read = 1;
        end
      end
      while (pi != 0 || pd != 0) begin
        exp_d = (pd != 0) && (pi == 0 || streak < MAX_D);
        if (exp_d) streak = (pi != 0) ? streak + 1 : 0;
        else streak = 0;
        wait_resp(gi, gd, cyc, cl);
        checks++;
        if ({gi, gd} !== {!exp_d, exp_d}) begin
          failures++;
          $display("FAIL rnd_grant%0d got=i%b d%b exp=d%b", r, gi, gd, exp_d);
        end
        if (!(gi || gd)) begin
          pi = 0;
          pd = 0;
          i_read = 0;
          d_read = 0;
          d_write = 0;
        end else if (gd) begin
          checks++;
          if (pd == 2) begin
            if (mem[lbase(da)] !== wd || wlog.size() != 4) begin
              failures++;
              $display("FAIL rnd_wr%0d got=%h n%0d exp=%h", r,
                       mem[lbase(da)], wlog.size(), wd);
            end
          end else if (d_rdata !== mem[lbase(da)]) begin
            failures++;
            $display("FAIL rnd_rd%0d got=%h exp=%h", r, d_rdata, mem[lbase(da)]);
          end
          if (have_i) begin
            checks++;
            if (i_rdata !== last_i) begin
              failures++;
              $display("FAIL rnd_ihold%0d got=%h exp=%h", r, i_rdata, last_i);
            end
          end
          d_read = 0;
          d_write = 0;
          pd = 0;
        end else begin
          checks++;
          if (i_rdata !== mem[lbase(ia)]) begin
            failures++;
            $display("FAIL rnd_i%0d got=%h exp=%h", r, i_rdata, mem[lbase(ia)]);
          end
          last_i = mem[lbase(ia)];
          have_i = 1;
          i_read = 0;
          pi = 0;
        end
      end
    end
    gap_mode = 0;
    tick();
  endtask

  initial begin
    rst = 1;
    i_read = 0;
    d_read = 0;
    d_write = 0;
    i_addr = '0;
    d_addr = '0;
    d_wdata = '0;
    @(negedge clk);
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_starvation();
    test_beat_gaps();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
